wb_ctrl: RTL and testbench

- Write-back controller that drives the register-file write port (w_ena/w_addr/w_data) from two result sources: the in-order MEM/WB pipeline result and a long-latency unit result (load miss or divider) delivered by a valid/ready handshake.
- Buffers long-latency results in a small FIFO and arbitrates them onto the single write port.
- Keeps a per-register busy scoreboard and raises a stall to the ID stage on RAW/WAW hazards against outstanding long-latency writes.

---
 rtl/wb_ctrl.sv | 138 +++++++++++++
 tb/tb_wb_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl.sv
// wb_ctrl: arbitrates MEM/WB and long-latency results onto the single register-file write port.
// Latency: a result selected in cycle N is on w_* in cycle N+1. Long-latency results are buffered in a FIFO first.
// Backpressure: the pipeline is never stalled; lr_ready_o drops only while the FIFO is full; id_stall_o flags RAW/WAW hazards.
module wb_ctrl #(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk_100MHz,
  input  logic            arst_n,
  input  logic            pipe_we_i,
  input  logic [RA_W-1:0] pipe_rd_i,
  input  logic [XLEN-1:0] pipe_data_i,
  input  logic            lr_valid_i,
  output logic            lr_ready_o,
  input  logic [RA_W-1:0] lr_rd_i,
  input  logic [XLEN-1:0] lr_data_i,
  input  logic            iss_lr_i,
  input  logic [RA_W-1:0] iss_rd_i,
  input  logic [RA_W-1:0] id_rs1_i,
  input  logic [RA_W-1:0] id_rs2_i,
  input  logic [RA_W-1:0] id_rd_i,
  output logic            id_stall_o,
  output logic            w_ena_o,
  output logic [RA_W-1:0] w_addr_o,
  output logic [XLEN-1:0] w_data_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 1 << RA_W;

  // Long-latency result buffer; storage needs no reset, validity lives in cnt_q.
  logic [RA_W-1:0]  fifo_rd_q   [FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            w_ena_q, w_ena_d;
  logic [RA_W-1:0] w_addr_q, w_addr_d;
  logic [XLEN-1:0] w_data_q, w_data_d;

  logic [NREG-1:0] busy_q, busy_d;
  // Set when the value currently on w_* came from the FIFO and its busy bit
  // should be released at the end of this cycle (one cycle conservative).
  logic            rel_vld_q, rel_vld_d;

  logic            push, pop, pipe_sel, head_wr;
  logic [RA_W-1:0] head_rd;
  logic [XLEN-1:0] head_data;

  assign lr_ready_o = (cnt_q != CNT_W'(FIFO_DEPTH));
  assign push       = lr_valid_i & lr_ready_o;
  assign pipe_sel   = pipe_we_i & (pipe_rd_i != '0);
  assign pop        = ~pipe_sel & (cnt_q != '0);
  assign head_rd    = fifo_rd_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];
  // x0 entries are drained silently.
  assign head_wr    = pop & (head_rd != '0);

  // FIFO storage write on accepted long-latency result.
  always_ff @(posedge clk_100MHz) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= lr_rd_i;
      fifo_data_q[wr_ptr_q] <= lr_data_i;
    end
  end

  // FIFO pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Write-port selection: pipeline first, then FIFO head; address/data hold when idle.
  always_comb begin
    w_ena_d  = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (pipe_sel) begin
      w_ena_d  = 1'b1;
      w_addr_d = pipe_rd_i;
      w_data_d = pipe_data_i;
    end else if (head_wr) begin
      w_ena_d  = 1'b1;
      w_addr_d = head_rd;
      w_data_d = head_data;
    end
  end

  // Scoreboard next-state: release the previously written FIFO register, then apply a new issue (set wins).
  always_comb begin
    busy_d = busy_q;
    if (rel_vld_q) busy_d[w_addr_q] = 1'b0;
    if (iss_lr_i)  busy_d[iss_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
    // A re-issue to the register being popped keeps it owned by the new op.
    rel_vld_d = head_wr & ~(iss_lr_i & (iss_rd_i == head_rd));
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      w_ena_q   <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      busy_q    <= '0;
      rel_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      w_ena_q   <= w_ena_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      busy_q    <= busy_d;
      rel_vld_q <= rel_vld_d;
    end
  end

  assign id_stall_o = busy_q[id_rs1_i] | busy_q[id_rs2_i] | busy_q[id_rd_i];
  assign w_ena_o    = w_ena_q;
  assign w_addr_o   = w_addr_q;
  assign w_data_o   = w_data_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// Testbench for wb_ctrl: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_wb_ctrl;

  localparam int DEPTH = 2;

  logic        clk_100MHz = 1'b0;
  logic        arst_n;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lr_valid;
  logic        lr_ready;
  logic [4:0]  lr_rd;
  logic [31:0] lr_data;
  logic        iss_lr;
  logic [4:0]  iss_rd;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_stall;
  logic        w_ena;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  int n_checks = 0;
  int n_fail   = 0;

  wb_ctrl #(.XLEN(32), .RA_W(5), .FIFO_DEPTH(DEPTH)) dut (
    .clk_100MHz (clk_100MHz),
    .arst_n     (arst_n),
    .pipe_we_i  (pipe_we),
    .pipe_rd_i  (pipe_rd),
    .pipe_data_i(pipe_data),
    .lr_valid_i (lr_valid),
    .lr_ready_o (lr_ready),
    .lr_rd_i    (lr_rd),
    .lr_data_i  (lr_data),
    .iss_lr_i   (iss_lr),
    .iss_rd_i   (iss_rd),
    .id_rs1_i   (id_rs1),
    .id_rs2_i   (id_rs2),
    .id_rd_i    (id_rd),
    .id_stall_o (id_stall),
    .w_ena_o    (w_ena),
    .w_addr_o   (w_addr),
    .w_data_o   (w_data)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Reference model: pending long-latency results in arrival order, busy flags,
  // and the expected contents of the write port.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  bit          m_busy[32];
  bit          m_rel_vld;
  logic [4:0]  m_rel_rd;
  bit          m_w_ena;
  logic [4:0]  m_w_addr;
  logic [31:0] m_w_data;

  function automatic bit m_ready();
    return m_q.size() < DEPTH;
  endfunction

  function automatic bit m_stall();
    return m_busy[id_rs1] | m_busy[id_rs2] | m_busy[id_rd];
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_rel_vld = 1'b0;
    m_rel_rd  = '0;
    m_w_ena   = 1'b0;
    m_w_addr  = '0;
    m_w_data  = '0;
  endtask

  task automatic zero_inputs();
    pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    lr_valid = 0; lr_rd = 0; lr_data = 0;
    iss_lr = 0; iss_rd = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
  endtask

  // Advance one clock: apply the cycle's inputs to the model, then sample point is edge+1.
  task automatic step();
    bit   rdy;
    bit   new_rel;
    ent_t h;
    logic [4:0] new_rel_rd;
    rdy        = m_ready();
    new_rel    = 1'b0;
    new_rel_rd = '0;
    m_w_ena    = 1'b0;
    if (pipe_we && pipe_rd != 0) begin
      m_w_ena  = 1'b1;
      m_w_addr = pipe_rd;
      m_w_data = pipe_data;
    end else if (m_q.size() > 0) begin
      h = m_q.pop_front();
      if (h.rd != 0) begin
        m_w_ena    = 1'b1;
        m_w_addr   = h.rd;
        m_w_data   = h.data;
        new_rel    = !(iss_lr && iss_rd == h.rd);
        new_rel_rd = h.rd;
      end
    end
    // A register frees up at the end of the cycle its value sits on the port.
    if (m_rel_vld) m_busy[m_rel_rd] = 1'b0;
    if (iss_lr && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    m_rel_vld = new_rel;
    m_rel_rd  = new_rel_rd;
    if (lr_valid && rdy) m_q.push_back({lr_rd, lr_data});
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic test_reset();
    zero_inputs();
    arst_n = 1'b0;
    #12;
    n_checks++; if (w_ena !== 1'b0) begin n_fail++; $display("FAIL reset_w_ena: got %0b expected 0", w_ena); end
    n_checks++; if (w_addr !== 5'd0) begin n_fail++; $display("FAIL reset_w_addr: got %0d expected 0", w_addr); end
    n_checks++; if (w_data !== 32'd0) begin n_fail++; $display("FAIL reset_w_data: got %0h expected 0", w_data); end
    @(posedge clk_100MHz); #1;
    arst_n = 1'b1;
    model_reset();
    #1;
    n_checks++; if (lr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_lr_ready: got %0b expected 1", lr_ready); end
    n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b expected 0", id_stall); end
  endtask

  task automatic test_pipe_write();
    pipe_we = 1; pipe_rd = 5; pipe_data = 32'h12345678;
    step();
    pipe_we = 0;
    n_checks++; if (w_ena !== 1'b1 || w_addr !== 5'd5 || w_data !== 32'h12345678)
      begin n_fail++; $display("FAIL pipe_write: got %0b/%0d/%h expected 1/5/12345678", w_ena, w_addr, w_data); end
    step();
    n_checks++; if (w_ena !== m_w_ena || w_addr !== m_w_addr)
      begin n_fail++; $display("FAIL pipe_write_one_cycle: got %0b/%0d expected %0b/%0d", w_ena, w_addr, m_w_ena, m_w_addr); end
  endtask

  task automatic test_lr_basic();
    iss_lr = 1; iss_rd = 7;
    step();
    iss_lr = 0; id_rs1 = 7;
    #1;
    n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL lr_stall_set: got %0b expected 1", id_stall); end
    lr_valid = 1; lr_rd = 7; lr_data = 32'hDEADBEEF;
    step();
    lr_valid = 0;
    n_checks++; if (w_ena !== 1'b0) begin n_fail++; $display("FAIL lr_not_yet: got %0b expected 0", w_ena); end
    step();
    n_checks++; if (w_ena !== 1'b1 || w_addr !== 5'd7 || w_data !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL lr_write: got %0b/%0d/%h expected 1/7/deadbeef", w_ena, w_addr, w_data); end
    n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL lr_stall_on_write: got %0b expected 1", id_stall); end
    step();
    n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL lr_stall_release: got %0b expected 0", id_stall); end
    id_rs1 = 0;
  endtask

  task automatic test_backpressure();
    int k = 0;
    bit acc;
    for (int cyc = 0; cyc < 10; cyc++) begin
      pipe_we   = (cyc < 4);
      pipe_rd   = 5'(cyc + 1);
      pipe_data = $urandom;
      lr_valid  = (k < 3);
      lr_rd     = 5'(20 + k);
      lr_data   = 32'hA000_0000 + 32'(k);
      #1;
      n_checks++; if (lr_ready !== m_ready())
        begin n_fail++; $display("FAIL bp_lr_ready cyc%0d: got %0b expected %0b", cyc, lr_ready, m_ready()); end
      acc = lr_valid && m_ready();
      step();
      if (acc) k++;
      n_checks++; if (w_ena !== m_w_ena || w_addr !== m_w_addr || w_data !== m_w_data)
        begin n_fail++; $display("FAIL bp_write cyc%0d: got %0b/%0d/%h expected %0b/%0d/%h", cyc, w_ena, w_addr, w_data, m_w_ena, m_w_addr, m_w_data); end
    end
    lr_valid = 0; pipe_we = 0;
    n_checks++; if (k != 3) begin n_fail++; $display("FAIL bp_all_accepted: got %0d expected 3", k); end
  endtask

  task automatic test_x0();
    pipe_we = 1; pipe_rd = 1; pipe_data = 32'h1111;
    lr_valid = 1; lr_rd = 9; lr_data = 32'h9999_0009;
    step();
    lr_valid = 0; pipe_rd = 0; pipe_data = 32'hBAD0;
    step();
    pipe_we = 0;
    n_checks++; if (w_ena !== 1'b1 || w_addr !== 5'd9 || w_data !== 32'h9999_0009)
      begin n_fail++; $display("FAIL x0_drain: got %0b/%0d/%h expected 1/9/99990009", w_ena, w_addr, w_data); end
    step();
    n_checks++; if (w_ena !== 1'b0) begin n_fail++; $display("FAIL x0_no_write: got %0b expected 0", w_ena); end
  endtask

  task automatic test_set_wins();
    iss_lr = 1; iss_rd = 3;
    step();
    iss_lr = 0;
    pipe_we = 1; pipe_rd = 2; pipe_data = 32'h2222;
    lr_valid = 1; lr_rd = 3; lr_data = 32'h3333;
    step();
    lr_valid = 0; pipe_we = 0;
    iss_lr = 1; iss_rd = 3;
    step();
    iss_lr = 0;
    n_checks++; if (w_ena !== 1'b1 || w_addr !== 5'd3)
      begin n_fail++; $display("FAIL setwins_pop: got %0b/%0d expected 1/3", w_ena, w_addr); end
    step();
    step();
    id_rd = 3;
    #1;
    n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL setwins_busy: got %0b expected 1", id_stall); end
    id_rd = 0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      iss_lr = 1; iss_rd = 5'(10 + i);
      step();
    end
    iss_lr = 0;
    pipe_we = 1; pipe_rd = 1; pipe_data = 32'h5;
    for (int i = 0; i < 2; i++) begin
      lr_valid = 1; lr_rd = 5'(13 + i); lr_data = 32'(i);
      step();
    end
    lr_valid = 0;
    id_rs1 = 10; id_rs2 = 11; id_rd = 12;
    #1;
    n_checks++; if (lr_ready !== 1'b0 || id_stall !== 1'b1 || w_ena !== 1'b1)
      begin n_fail++; $display("FAIL mid_pre: got ready%0b stall%0b ena%0b expected 0/1/1", lr_ready, id_stall, w_ena); end
    #1 arst_n = 1'b0;
    #1;
    n_checks++; if (w_ena !== 1'b0) begin n_fail++; $display("FAIL mid_w_ena: got %0b expected 0", w_ena); end
    n_checks++; if (lr_ready !== 1'b1) begin n_fail++; $display("FAIL mid_lr_ready: got %0b expected 1", lr_ready); end
    n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL mid_stall: got %0b expected 0", id_stall); end
    zero_inputs();
    model_reset();
    @(posedge clk_100MHz); #1;
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (w_ena !== 1'b0) begin n_fail++; $display("FAIL mid_after w_ena cyc%0d: got %0b expected 0", i, w_ena); end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      id_rs1    = 5'($urandom);
      id_rs2    = 5'($urandom);
      id_rd     = 5'($urandom);
      pipe_we   = ($urandom_range(0, 2) == 0);
      pipe_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      pipe_data = $urandom;
      lr_valid  = $urandom_range(0, 1);
      lr_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      lr_data   = $urandom;
      iss_rd    = 5'($urandom_range(1, 31));
      iss_lr    = !m_stall() && ($urandom_range(0, 3) == 0);
      #1;
      n_checks++; if (lr_ready !== m_ready())
        begin n_fail++; $display("FAIL rnd_lr_ready cyc%0d: got %0b expected %0b", cyc, lr_ready, m_ready()); end
      n_checks++; if (id_stall !== m_stall())
        begin n_fail++; $display("FAIL rnd_stall cyc%0d: got %0b expected %0b", cyc, id_stall, m_stall()); end
      step();
      n_checks++; if (w_ena !== m_w_ena || w_addr !== m_w_addr || w_data !== m_w_data)
        begin n_fail++; $display("FAIL rnd_write cyc%0d: got %0b/%0d/%h expected %0b/%0d/%h", cyc, w_ena, w_addr, w_data, m_w_ena, m_w_addr, m_w_data); end
    end
    zero_inputs();
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_lr_basic();
    test_backpressure();
    test_x0();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
